// File: rtl/k423_lsu_ctrl.sv
// Execute-stage load/store control: alignment check, word-aligned request build,
// and a four-state tracker for the single outstanding data-memory transaction.
module k423_lsu_ctrl #(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              ex_lsu_vld_i,
    input  logic              ex_lsu_store_i,
    input  logic [1:0]        ex_lsu_size_i,
    input  logic [ADDR_W-1:0] ex_lsu_addr_i,
    input  logic [XLEN-1:0]   ex_lsu_wdata_i,
    output logic              mem_data_req_vld_o,
    input  logic              mem_data_req_rdy_i,
    output logic [ADDR_W-1:0] mem_data_req_addr_o,
    output logic              mem_data_req_we_o,
    output logic [3:0]        mem_data_req_wstrb_o,
    output logic [XLEN-1:0]   mem_data_req_wdata_o,
    input  logic              mem_data_rsp_vld_i,
    output logic              lsu_busy_o,
    output logic              lsu_done_o,
    output logic              lsu_excp_misalign_o,
    output logic [CNT_W-1:0]  lsu_stall_cnt_o
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

    state_t state_q, state_nxt;

    logic [ADDR_W-1:0] req_addr_p1;
    logic              req_we_p1;
    logic [3:0]        req_wstrb_p1;
    logic [XLEN-1:0]   req_wdata_p1;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic              accept;
    logic              misaligned;

    // Size 2'b11 falls into the word case everywhere below.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   return 1'b0;
            2'b01:   return off[0];
            default: return off != 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] byte_strobe(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] replicate_wdata(input logic [1:0] size,
                                                        input logic [XLEN-1:0] wdata);
        case (size)
            2'b00:   return {4{wdata[7:0]}};
            2'b01:   return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    assign misaligned = is_misaligned(ex_lsu_size_i, ex_lsu_addr_i[1:0]);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt           = state_q;
        accept              = 1'b0;
        lsu_done_o          = 1'b0;
        lsu_excp_misalign_o = 1'b0;
        mem_data_req_vld_o  = 1'b0;
        case (state_q)
            IDLE: begin
                if (ex_lsu_vld_i && !flush_i) begin
                    if (misaligned) begin
                        lsu_excp_misalign_o = 1'b1;
                        lsu_done_o          = 1'b1;
                    end else begin
                        accept    = 1'b1;
                        state_nxt = REQ;
                    end
                end
            end
            REQ: begin
                mem_data_req_vld_o = 1'b1;
                // A flush racing the handshake still leaves a response in flight.
                if (flush_i) begin
                    state_nxt = mem_data_req_rdy_i ? DRAIN : IDLE;
                end else if (mem_data_req_rdy_i) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (mem_data_rsp_vld_i) begin
                    lsu_done_o = !flush_i;
                    state_nxt  = IDLE;
                end else if (flush_i) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (mem_data_rsp_vld_i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture stage: fields are frozen from acceptance until the next op.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_addr_p1  <= '0;
            req_we_p1    <= 1'b0;
            req_wstrb_p1 <= 4'b0000;
            req_wdata_p1 <= '0;
        end else if (accept) begin
            req_addr_p1  <= {ex_lsu_addr_i[ADDR_W-1:2], 2'b00};
            req_we_p1    <= ex_lsu_store_i;
            req_wstrb_p1 <= ex_lsu_store_i ? byte_strobe(ex_lsu_size_i, ex_lsu_addr_i[1:0]) : 4'b0000;
            req_wdata_p1 <= ex_lsu_store_i ? replicate_wdata(ex_lsu_size_i, ex_lsu_wdata_i) : '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else if (state_q != IDLE && stall_cnt_q != {CNT_W{1'b1}}) begin
            stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign mem_data_req_addr_o  = req_addr_p1;
    assign mem_data_req_we_o    = req_we_p1;
    assign mem_data_req_wstrb_o = req_wstrb_p1;
    assign mem_data_req_wdata_o = req_wdata_p1;
    assign lsu_busy_o           = state_q != IDLE;
    assign lsu_stall_cnt_o      = stall_cnt_q;

endmodule
